// File: rtl/sram_pipe.sv
// rtl/sram_pipe.sv - pipelined single-port SRAM with byte enables, post-reset clear and in-order responses
// Requests accepted in RUN flow through READ_LATENCY response stages; the last stage is the output register.
module sram_pipe #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_DEPTH   = 4096,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    we_n_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   data_in_i,
    output logic                    rsp_valid_o,
    output logic                    rsp_is_write_o,
    output logic [DATA_WIDTH-1:0]   data_out_o,
    output logic                    addr_err_o,
    output logic                    init_done_o
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int IDX_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int LAT   = READ_LATENCY;
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DATA_DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

    logic                  accept;
    logic                  in_range;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_we;
    logic [IDX_W-1:0]      mem_idx;
    logic [NB-1:0]         mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;

    logic                  vld_q [LAT];
    logic                  vld_d [LAT];
    logic                  wr_q  [LAT];
    logic                  wr_d  [LAT];
    logic                  err_q [LAT];
    logic                  err_d [LAT];
    logic [DATA_WIDTH-1:0] dat_q [LAT];
    logic [DATA_WIDTH-1:0] dat_d [LAT];

    assign req_ready_o = (state_q == ST_RUN);
    assign init_done_o = (state_q == ST_RUN);
    assign accept      = req_valid_i & req_ready_o;
    assign in_range    = ({1'b0, addr_i} < DEPTH_A);
    assign req_idx     = addr_i[IDX_W-1:0];
    // Array read sees contents before the accepting edge, so a write one cycle earlier is already visible.
    assign rd_data     = in_range ? mem_q[req_idx] : '0;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_be    = be_i;
        mem_wdata = data_in_i;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_idx   = cnt_q;
                mem_be    = '1;
                mem_wdata = '0;
                cnt_d     = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                mem_we = accept & ~we_n_i & in_range;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (mem_be[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        vld_d[0] = accept;
        wr_d[0]  = accept & ~we_n_i;
        err_d[0] = accept & ~in_range;
        dat_d[0] = rd_data;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            wr_d[i]  = wr_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        // The output stage only takes new data from a read response; otherwise it holds.
        if (!(vld_d[LAT-1] && !wr_d[LAT-1])) begin
            dat_d[LAT-1] = dat_q[LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                wr_q[i]  <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= vld_d[i];
                wr_q[i]  <= wr_d[i];
                err_q[i] <= err_d[i];
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign rsp_valid_o    = vld_q[LAT-1];
    assign rsp_is_write_o = wr_q[LAT-1];
    assign addr_err_o     = err_q[LAT-1];
    assign data_out_o     = dat_q[LAT-1];
endmodule

// File: doc/sram_pipe.md
# sram_pipe

Parametrised, pipelined single-port synchronous RAM for the Mano machine memory subsystem. It generalises the basic 16-bit word SRAM with configurable width, depth and read latency, byte-enabled writes, and a valid/ready request port. It also adds an in-order response channel, out-of-range address detection and a self-clearing initialisation sequence after reset. It sits between the CPU memory sequencer (AR/DR path) and the instruction/data store.

## Interface
Parameters:
- ADDR_WIDTH, 16, request address width
- DATA_WIDTH, 16, word width; must be a multiple of 8
- DATA_DEPTH, 4096, number of words; must be ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1, cycles from request acceptance to response; legal range 1..4

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- we_n  in  1  0 = write, 1 = read; qualified by req_valid
- be  in  DATA_WIDTH/8  byte enables for writes; bit i selects data_in[8i+7:8i]; ignored on reads
- addr  in  ADDR_WIDTH  word address
- data_in  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_is_write  out  1  response belongs to a write (acknowledge)
- data_out  out  DATA_WIDTH  read data
- addr_err  out  1  response address was ≥ DATA_DEPTH
- init_done  out  1  memory clear is complete

## Operation
- **States:**
  - INIT: counter runs 0..DATA_DEPTH-1, writing 0 to one word per cycle; req_ready=0.
  - RUN: reached after the final clear write; req_ready=1 and init_done=1 permanently until the next reset.
- **Acceptance:** a request is accepted when req_valid & req_ready is high at a rising edge. One request per cycle. Requests while req_ready=0 are ignored, with no response and no memory change.
- **Write:** accepted with addr < DATA_DEPTH. Each byte with be[i]=1 is updated at the accepting edge. Bytes with be[i]=0 keep their old value. be=0 performs no change but still produces an acknowledge.
- **Read:** returns mem[addr] as of the accepting edge.
- **Read-after-write:** a read accepted one cycle after a write to the same address returns the new data.
- **Out-of-range (addr ≥ DATA_DEPTH):**
  - Writes are discarded.
  - Reads return data_out=0.
  - Both produce a response with addr_err=1.
- **Responses:** every accepted request produces exactly one response, in acceptance order.
  - Reads: rsp_is_write=0.
  - Writes: rsp_is_write=1, and data_out holds its previous value.
- **Output holding:** data_out changes only on read responses. It holds the last read value otherwise, including while rsp_valid=0.
- **addr_err and rsp_is_write:** valid only while rsp_valid=1; 0 otherwise.
- **Reset:**
  - rst_n low immediately forces all outputs to 0 and flushes every pipeline stage; in-flight responses are dropped.
  - The INIT counter goes to 0 and INIT restarts when rst_n rises.
  - Reset is legal at any point, including mid-INIT and mid-burst.
- **Array state:** the array itself is not reset asynchronously; the INIT sequence is its only clearing mechanism.

## Timing
- **Reset values:** req_ready=0, rsp_valid=0, rsp_is_write=0, data_out=0, addr_err=0, init_done=0.
- **INIT:** occupies the first DATA_DEPTH rising edges after rst_n deasserts. req_ready and init_done are driven high by edge DATA_DEPTH and are visible in the following cycle.
- **Response latency:** for a request accepted at edge k, the response is registered by edge k+READ_LATENCY-1. rsp_valid is high for exactly the one cycle following that edge.
- **Throughput:** back-to-back requests give back-to-back rsp_valid pulses. Sustained throughput is one request per cycle at every latency.
- **Backpressure:** there is no response backpressure; the consumer must always accept rsp_valid.
- **req_ready:** depends only on state, never on req_valid.

## Test plan
1. **Reset and clear.** Pulse rst_n low, DATA_DEPTH=16, READ_LATENCY=1; pre-load garbage via a prior run.
   - req_ready=0 for 16 cycles after release, then 1, with init_done=1.
   - Reading all 16 addresses returns 0x0000.
2. **Latency and throughput.** READ_LATENCY=3.
   - Write 0x1234@5 and 0xBEEF@6, then read 5,6 back-to-back.
   - Write acks appear 3 cycles after acceptance with rsp_is_write=1.
   - Reads give consecutive rsp_valid pulses with data_out=0x1234 then 0xBEEF.
3. **Byte enables.**
   - Write 0xAAAA@2 with be=2'b11, then 0x5555@2 with be=2'b01.
   - Read 2 → 0xAA55.
   - A be=2'b00 write returns an ack; the word is unchanged.
4. **Out of range.** DATA_DEPTH=16, read addr 20 and write 0xFFFF@20.
   - Both responses have addr_err=1, and the read gives data_out=0.
   - Reads of addresses 0..15 are unchanged, so the out-of-range write aliased nowhere.
5. **Read-after-write and hold.** Write 0x0F0F@7, read 7 on the next cycle.
   - The read returns 0x0F0F.
   - Then 10 idle cycles: data_out stays 0x0F0F and rsp_valid=0.
6. **Reset mid-operation.** READ_LATENCY=4: issue 3 reads, then assert rst_n 2 cycles later.
   - All outputs read 0 at once, and no stale responses ever appear.
   - INIT restarts from address 0.
   - Assert reset again mid-INIT: the clear restarts and completes in full.
